// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the two-master picorv32 bus arbiter: FSM states,
// one-hot grant encodings and default timeout behaviour.
package mem_arbiter_pkg;

    // Arbiter ownership states
    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StOwn0 = 2'b01,
        StOwn1 = 2'b10
    } arb_state_e;

    // One-hot grant encodings
    localparam logic [1:0] GRANT_NONE = 2'b00;
    localparam logic [1:0] GRANT_M0   = 2'b01;
    localparam logic [1:0] GRANT_M1   = 2'b10;

    // Default forced-completion behaviour
    localparam int unsigned DEFAULT_TIMEOUT  = 1000;
    localparam logic [31:0] DEFAULT_ERR_DATA = 32'hFFFF_FFFF;

    // Wait counter width and timeout event counter ceiling
    localparam int unsigned WAIT_W        = 16;
    localparam logic [7:0]  TMO_COUNT_MAX = 8'hFF;

endpackage

// File: rtl/mem_arbiter.sv
// Two-master round-robin arbiter for the picorv32 native memory bus. One
// transfer at a time owns the shared slave bus; a stalled slave is forcibly
// completed with ERR_DATA after TIMEOUT granted cycles.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT  = DEFAULT_TIMEOUT,
    parameter logic [31:0] ERR_DATA = DEFAULT_ERR_DATA
) (
    input  logic        clk,
    input  logic        reset,
    // master 0
    input  logic        m0_valid,
    input  logic        m0_instr,
    input  logic [3:0]  m0_wstrb,
    input  logic [31:0] m0_wdata,
    input  logic [31:0] m0_addr,
    output logic        m0_ready,
    output logic [31:0] m0_rdata,
    // master 1
    input  logic        m1_valid,
    input  logic        m1_instr,
    input  logic [3:0]  m1_wstrb,
    input  logic [31:0] m1_wdata,
    input  logic [31:0] m1_addr,
    output logic        m1_ready,
    output logic [31:0] m1_rdata,
    // shared slave bus
    output logic        s_valid,
    output logic        s_instr,
    output logic [3:0]  s_wstrb,
    output logic [31:0] s_wdata,
    output logic [31:0] s_addr,
    input  logic        s_ready,
    input  logic [31:0] s_rdata,
    // status
    output logic [1:0]  grant,
    output logic        timeout_flag,
    output logic [7:0]  timeout_count
);

    // Counter value seen in the last allowed granted cycle
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

    arb_state_e        state_q;
    logic [1:0]        grant_q;
    logic [1:0]        last_grant_q;
    logic [WAIT_W-1:0] wait_cnt_q;
    logic              timeout_flag_q;
    logic [7:0]        timeout_count_q;

    logic own0;
    logic own1;
    logic own_valid;
    logic done_ok;
    logic tmo_hit;

    // Decode the current owner and its completion conditions; reset masks ownership.
    always_comb begin
        own0      = (state_q == StOwn0) && !reset;
        own1      = (state_q == StOwn1) && !reset;
        own_valid = (own0 && m0_valid) || (own1 && m1_valid);
        // Slave ready wins over a coincident timeout
        done_ok   = own_valid && s_ready;
        tmo_hit   = own_valid && !s_ready && (wait_cnt_q == WAIT_LAST);
    end

    // Forward the owner's request to the slave bus; zeros when nobody owns it.
    always_comb begin
        s_valid = own_valid && !tmo_hit;
        s_instr = 1'b0;
        s_wstrb = '0;
        s_wdata = '0;
        s_addr  = '0;
        if (own0) begin
            s_instr = m0_instr;
            s_wstrb = m0_wstrb;
            s_wdata = m0_wdata;
            s_addr  = m0_addr;
        end else if (own1) begin
            s_instr = m1_instr;
            s_wstrb = m1_wstrb;
            s_wdata = m1_wdata;
            s_addr  = m1_addr;
        end
    end

    // Return path: owner sees the slave response directly, or ERR_DATA on timeout.
    always_comb begin
        m0_ready = own0 && (done_ok || tmo_hit);
        m1_ready = own1 && (done_ok || tmo_hit);
        m0_rdata = '0;
        m1_rdata = '0;
        if (own0) begin
            m0_rdata = tmo_hit ? ERR_DATA : s_rdata;
        end
        if (own1) begin
            m1_rdata = tmo_hit ? ERR_DATA : s_rdata;
        end
    end

    // Arbitration FSM with registered grant, wait counter and timeout bookkeeping.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= StIdle;
            grant_q         <= GRANT_NONE;
            last_grant_q    <= GRANT_M1;
            wait_cnt_q      <= '0;
            timeout_flag_q  <= 1'b0;
            timeout_count_q <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    wait_cnt_q <= '0;
                    if (m0_valid && (!m1_valid || last_grant_q == GRANT_M1)) begin
                        state_q <= StOwn0;
                        grant_q <= GRANT_M0;
                    end else if (m1_valid) begin
                        state_q <= StOwn1;
                        grant_q <= GRANT_M1;
                    end
                end
                StOwn0, StOwn1: begin
                    if (!own_valid) begin
                        // Master abandoned its request: drop it without a handshake
                        state_q <= StIdle;
                        grant_q <= GRANT_NONE;
                    end else if (done_ok || tmo_hit) begin
                        state_q      <= StIdle;
                        grant_q      <= GRANT_NONE;
                        last_grant_q <= grant_q;
                        if (tmo_hit) begin
                            timeout_flag_q <= 1'b1;
                            if (timeout_count_q != TMO_COUNT_MAX) begin
                                timeout_count_q <= timeout_count_q + 8'd1;
                            end
                        end
                    end else begin
                        wait_cnt_q <= wait_cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    grant_q <= GRANT_NONE;
                end
            endcase
        end
    end

    assign grant         = grant_q;
    assign timeout_flag  = timeout_flag_q;
    assign timeout_count = timeout_count_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: expected completions are queued when
// stimulus is issued and a negedge monitor pops them as masters see ready.
module tb_mem_arbiter;

    localparam int unsigned TB_TIMEOUT = 8;

    logic        clk;
    logic        reset;
    logic        m0_valid, m0_instr, m0_ready;
    logic [3:0]  m0_wstrb;
    logic [31:0] m0_wdata, m0_addr, m0_rdata;
    logic        m1_valid, m1_instr, m1_ready;
    logic [3:0]  m1_wstrb;
    logic [31:0] m1_wdata, m1_addr, m1_rdata;
    logic        s_valid, s_instr, s_ready;
    logic [3:0]  s_wstrb;
    logic [31:0] s_wdata, s_addr, s_rdata;
    logic [1:0]  grant;
    logic        timeout_flag;
    logic [7:0]  timeout_count;

    typedef struct {
        int          master;
        logic [31:0] rdata;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // slave model controls
    int          slave_delay = 0;   // granted cycles before ready; -1 = never
    bit          fixed_en    = 0;
    logic [31:0] fixed_data  = '0;

    mem_arbiter #(
        .TIMEOUT  (TB_TIMEOUT),
        .ERR_DATA (32'hFFFF_FFFF)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .m0_valid      (m0_valid),
        .m0_instr      (m0_instr),
        .m0_wstrb      (m0_wstrb),
        .m0_wdata      (m0_wdata),
        .m0_addr       (m0_addr),
        .m0_ready      (m0_ready),
        .m0_rdata      (m0_rdata),
        .m1_valid      (m1_valid),
        .m1_instr      (m1_instr),
        .m1_wstrb      (m1_wstrb),
        .m1_wdata      (m1_wdata),
        .m1_addr       (m1_addr),
        .m1_ready      (m1_ready),
        .m1_rdata      (m1_rdata),
        .s_valid       (s_valid),
        .s_instr       (s_instr),
        .s_wstrb       (s_wstrb),
        .s_wdata       (s_wdata),
        .s_addr        (s_addr),
        .s_ready       (s_ready),
        .s_rdata       (s_rdata),
        .grant         (grant),
        .timeout_flag  (timeout_flag),
        .timeout_count (timeout_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] slave_fn(input logic [31:0] addr);
        return addr ^ 32'h5A5A_0000;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic push_exp(input int m, input logic [31:0] d);
        exp_t e;
        e.master = m;
        e.rdata  = d;
        exp_q.push_back(e);
    endtask

    task automatic drive(input int m, input logic v, input logic [31:0] a,
                         input logic [31:0] wd, input logic [3:0] ws);
        if (m == 0) begin
            m0_valid = v; m0_addr = a; m0_wdata = wd; m0_wstrb = ws; m0_instr = 1'b0;
        end else begin
            m1_valid = v; m1_addr = a; m1_wdata = wd; m1_wstrb = ws; m1_instr = 1'b0;
        end
    endtask

    // Hold a request until the master sees ready (bounded), then release it.
    task automatic xfer(input int m, input logic [31:0] a, input logic [31:0] wd,
                        input logic [3:0] ws);
        logic seen;
        seen = 1'b0;
        drive(m, 1'b1, a, wd, ws);
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            seen = (m == 0) ? m0_ready : m1_ready;
        end
        check("xfer_done", {31'd0, seen}, 32'd1);
        @(posedge clk); #1;
        drive(m, 1'b0, '0, '0, '0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drive(0, 1'b0, '0, '0, '0);
        drive(1, 1'b0, '0, '0, '0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    // Slave: respond slave_delay granted cycles after ownership starts.
    initial begin
        int busy;
        busy    = 0;
        s_ready = 1'b0;
        s_rdata = '0;
        forever begin
            @(posedge clk); #1;
            if (grant != 2'b00 && !reset) begin
                if (slave_delay >= 0 && busy == slave_delay) begin
                    s_ready = 1'b1;
                    s_rdata = fixed_en ? fixed_data : slave_fn(s_addr);
                end else begin
                    s_ready = 1'b0;
                    s_rdata = '0;
                end
                busy++;
            end else begin
                busy    = 0;
                s_ready = 1'b0;
                s_rdata = '0;
            end
        end
    end

    // Monitor: pop and compare on every master ready.
    initial begin
        forever begin
            @(negedge clk);
            if (!reset && (m0_ready || m1_ready)) begin
                check("sb_single_ready", {31'd0, m0_ready & m1_ready}, 32'd0);
                if (exp_q.size() == 0) begin
                    check("sb_unexpected_ready", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("sb_master", m1_ready ? 32'd1 : 32'd0, e.master);
                    check("sb_rdata", m1_ready ? m1_rdata : m0_rdata, e.rdata);
                    check("sb_grant", {30'd0, grant}, (e.master == 0) ? 32'd1 : 32'd2);
                end
            end
        end
    end

    initial begin
        reset = 1'b1;
        drive(0, 1'b0, '0, '0, '0);
        drive(1, 1'b0, '0, '0, '0);

        // Reset state
        do_reset();
        @(negedge clk);
        check("rst_grant", {30'd0, grant}, 32'd0);
        check("rst_svalid", {31'd0, s_valid}, 32'd0);
        check("rst_tflag", {31'd0, timeout_flag}, 32'd0);
        check("rst_tcount", {24'd0, timeout_count}, 32'd0);
        @(posedge clk); #1;

        // m0 single read, slave ready after 2 cycles
        slave_delay = 2; fixed_en = 1; fixed_data = 32'h1234_5678;
        push_exp(0, 32'h1234_5678);
        fork
            xfer(0, 32'h0000_0100, '0, 4'b0000);
            begin
                @(negedge clk);
                check("t1_idle_svalid", {31'd0, s_valid}, 32'd0);
                check("t1_idle_grant", {30'd0, grant}, 32'd0);
                check("t1_idle_saddr", s_addr, 32'd0);
                @(negedge clk);
                check("t1_svalid", {31'd0, s_valid}, 32'd1);
                check("t1_grant", {30'd0, grant}, 32'd1);
                check("t1_saddr", s_addr, 32'h0000_0100);
            end
        join
        @(negedge clk);
        check("t1_grant_back", {30'd0, grant}, 32'd0);

        // Simultaneous requests, three each: strict alternation starting with m0
        do_reset();
        slave_delay = 1; fixed_en = 0;
        for (int k = 0; k < 3; k++) begin
            push_exp(0, slave_fn(32'h400 + 32'(4 * k)));
            push_exp(1, slave_fn(32'h500 + 32'(4 * k)));
        end
        fork
            for (int k = 0; k < 3; k++) xfer(0, 32'h400 + 32'(4 * k), '0, 4'b0000);
            for (int k = 0; k < 3; k++) xfer(1, 32'h500 + 32'(4 * k), '0, 4'b0000);
        join

        // m1 GPIO write holds the bus while m0 waits
        do_reset();
        slave_delay = 4;
        push_exp(1, slave_fn(32'h1000_0000));
        push_exp(0, slave_fn(32'h0000_0200));
        fork
            xfer(1, 32'h1000_0000, 32'h0000_00A5, 4'b0001);
            begin
                @(posedge clk); #1;
                xfer(0, 32'h0000_0200, '0, 4'b0000);
            end
            begin
                logic done;
                done = 1'b0;
                @(negedge clk);
                @(negedge clk);
                check("t3_grant_m1", {30'd0, grant}, 32'd2);
                check("t3_wdata", s_wdata, 32'h0000_00A5);
                check("t3_wstrb", {28'd0, s_wstrb}, 32'd1);
                for (int i = 0; i < 20 && !done; i++) begin
                    if (m1_ready) done = 1'b1;
                    else @(negedge clk);
                end
                check("t3_m1_done", {31'd0, done}, 32'd1);
                @(negedge clk);
                check("t3_idle_gap", {30'd0, grant}, 32'd0);
                @(negedge clk);
                check("t3_grant_m0", {30'd0, grant}, 32'd1);
            end
        join

        // Slave never ready: forced completion in the 8th granted cycle
        do_reset();
        slave_delay = -1;
        push_exp(0, 32'hFFFF_FFFF);
        fork
            xfer(0, 32'h0000_0300, '0, 4'b0000);
            begin
                int  n;
                logic hit;
                n   = 0;
                hit = 1'b0;
                for (int i = 0; i < 30 && !hit; i++) begin
                    @(negedge clk);
                    if (grant == 2'b01) n++;
                    if (m0_ready) begin
                        hit = 1'b1;
                        check("t4_svalid_off", {31'd0, s_valid}, 32'd0);
                    end
                end
                check("t4_granted_cycles", n, TB_TIMEOUT);
            end
        join
        @(negedge clk);
        check("t4_tflag", {31'd0, timeout_flag}, 32'd1);
        check("t4_tcount", {24'd0, timeout_count}, 32'd1);
        @(posedge clk); #1;

        // Slave ready exactly in the last allowed cycle: normal completion
        do_reset();
        slave_delay = TB_TIMEOUT - 1; fixed_en = 1; fixed_data = 32'hCAFE_0040;
        push_exp(0, 32'hCAFE_0040);
        xfer(0, 32'h0000_0340, '0, 4'b0000);
        @(negedge clk);
        check("t5_tflag", {31'd0, timeout_flag}, 32'd0);
        check("t5_tcount", {24'd0, timeout_count}, 32'd0);
        @(posedge clk); #1;

        // Reset mid-transfer while m1 owns the bus
        do_reset();
        slave_delay = -1; fixed_en = 0;
        drive(1, 1'b1, 32'h0000_0700, '0, 4'b0000);
        repeat (3) @(negedge clk);
        check("t6_pre_grant", {30'd0, grant}, 32'd2);
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        check("t6_rst_svalid", {31'd0, s_valid}, 32'd0);
        check("t6_rst_m1ready", {31'd0, m1_ready}, 32'd0);
        check("t6_rst_rdata", m0_rdata | m1_rdata, 32'd0);
        @(negedge clk);
        check("t6_grant_cleared", {30'd0, grant}, 32'd0);
        check("t6_svalid_cleared", {31'd0, s_valid}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        slave_delay = 0;
        push_exp(0, slave_fn(32'h0000_0600));
        push_exp(1, slave_fn(32'h0000_0700));
        fork
            xfer(0, 32'h0000_0600, '0, 4'b0000);
            xfer(1, 32'h0000_0700, '0, 4'b0000);
        join

        repeat (3) @(negedge clk);
        check("sb_drain", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required finish before 200000");
        $fatal(1);
    end

endmodule
